// File: rtl/imm_decode_sequencer_pkg.sv
// Shared constants for the immediate-decode sequencer: selection codes,
// RV64I major opcodes and the sequencer state encoding.
package imm_decode_sequencer_pkg;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_U    = 3'd2;
    localparam logic [2:0] SEL_S    = 3'd3;
    localparam logic [2:0] SEL_B    = 3'd4;
    localparam logic [2:0] SEL_UJ   = 3'd5;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/imm_decode_sequencer_imm_sel_lut.sv
// Combinational opcode classifier producing the generator selection code
// and an illegal-opcode flag.
module imm_sel_lut
    import imm_decode_sequencer_pkg::*;
(
    input  logic [6:0] OPCODE,
    output logic [2:0] IMM_SEL,
    output logic       ILLEGAL
);

    // Opcode lookup; register-register ops are legal but carry no immediate.
    always_comb begin
        IMM_SEL = SEL_NONE;
        ILLEGAL = 1'b1;
        case (OPCODE)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                IMM_SEL = SEL_I;
                ILLEGAL = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                IMM_SEL = SEL_U;
                ILLEGAL = 1'b0;
            end
            OP_STORE: begin
                IMM_SEL = SEL_S;
                ILLEGAL = 1'b0;
            end
            OP_BRANCH: begin
                IMM_SEL = SEL_B;
                ILLEGAL = 1'b0;
            end
            OP_JAL: begin
                IMM_SEL = SEL_UJ;
                ILLEGAL = 1'b0;
            end
            OP_OP, OP_OP32: begin
                IMM_SEL = SEL_NONE;
                ILLEGAL = 1'b0;
            end
            default: begin
                IMM_SEL = SEL_NONE;
                ILLEGAL = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Registered immediate generator: one-cycle latency, output is not reset.
// SELECTION codes: 1=I, 2=U, 3=S, 4=B, 5=UJ, anything else yields 0.
module instruction_decoder (
    input  logic        CLK,
    input  logic [31:0] INSTRUCTION,
    input  logic [2:0]  SELECTION,
    output logic [63:0] VALUE
);

    logic unused_opcode_s;
    assign unused_opcode_s = ^INSTRUCTION[6:0];

    // Sign-extended immediate assembly, registered once per cycle.
    always_ff @(posedge CLK) begin
        case (SELECTION)
            3'd1:    VALUE <= {{52{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
            3'd2:    VALUE <= {{32{INSTRUCTION[31]}}, INSTRUCTION[31:12], 12'd0};
            3'd3:    VALUE <= {{52{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
            3'd4:    VALUE <= {{51{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                               INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
            3'd5:    VALUE <= {{43{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                               INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
            default: VALUE <= 64'd0;
        endcase
    end

endmodule

// File: rtl/imm_decode_sequencer.sv
// Decode front-end: latches one fetched instruction, waits out the registered
// immediate generator, then holds the decoded bundle until downstream accepts.
module imm_decode_sequencer
    import imm_decode_sequencer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               FLUSH,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [31:0]        INSTRUCTION,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [63:0]        IMM,
    output logic [6:0]         OPCODE,
    output logic [4:0]         RD,
    output logic [4:0]         RS1,
    output logic [4:0]         RS2,
    output logic [2:0]         FUNCT3,
    output logic [6:0]         FUNCT7,
    output logic [2:0]         IMM_SEL,
    output logic               ILLEGAL,
    output logic [COUNT_W-1:0] DECODED_COUNT
);

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        instr_r;
    logic [COUNT_W-1:0] count_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               inc_s;
    logic [63:0]        value_s;
    logic [2:0]         sel_s;

    imm_sel_lut u_lut (
        .OPCODE  (instr_r[6:0]),
        .IMM_SEL (sel_s),
        .ILLEGAL (ILLEGAL)
    );

    instruction_decoder u_gen (
        .CLK         (CLK),
        .INSTRUCTION (instr_r),
        .SELECTION   (sel_s),
        .VALUE       (value_s)
    );

    // Next-state, handshake and counter-enable decode; FLUSH overrides all.
    always_comb begin
        state_s    = state_r;
        inc_s      = 1'b0;
        in_ready_s = ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && OUT_READY))
                     && !FLUSH && !RESET;
        accept_s   = IN_VALID && in_ready_s;
        if (FLUSH) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = ST_GEN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_GEN: begin
                    state_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        inc_s = 1'b1;
                        if (accept_s) begin
                            state_s = ST_GEN;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, instruction latch and completed-handshake counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            instr_r <= NOP_INSTR;
            count_r <= {COUNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                instr_r <= INSTRUCTION;
            end
            if (inc_s) begin
                count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign IN_READY      = in_ready_s;
    assign OUT_VALID     = (state_r == ST_HOLD);
    // The generator output is unreset and lags the latch, so expose it only in HOLD.
    assign IMM           = (state_r == ST_HOLD) ? value_s : 64'd0;
    assign OPCODE        = instr_r[6:0];
    assign RD            = instr_r[11:7];
    assign FUNCT3        = instr_r[14:12];
    assign RS1           = instr_r[19:15];
    assign RS2           = instr_r[24:20];
    assign FUNCT7        = instr_r[31:25];
    assign IMM_SEL       = sel_s;
    assign DECODED_COUNT = count_r;

endmodule
